// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two RAM operands, drives an external registered ALU,
// then writes the result back to RAM. One command in flight at a time.
module alu_sequencer #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_src_a_i,
   input  logic [ADDR_W-1:0] cmd_src_b_i,
   input  logic [ADDR_W-1:0] cmd_dst_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_re_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              mem_we_o,
   output logic [7:0]        mem_wdata_o,
   output logic [7:0]        alu_a_o,
   output logic [7:0]        alu_b_o,
   output logic [1:0]        alu_opcode_o,
   input  logic [7:0]        alu_result_i,
   output logic              done_o,
   output logic [7:0]        done_result_o,
   output logic [7:0]        op_count_o
);

   typedef enum logic [2:0] {StIdle, StRdA, StRdB, StLoad, StExec, StWb} state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   src_a_q, src_b_q, dst_q;
   logic [7:0]          opa_q;
   logic [7:0]          alu_a_q, alu_b_q;
   logic [1:0]          alu_op_q;
   logic [7:0]          done_result_q;
   logic [7:0]          op_count_q;
   logic                accept;

   assign accept = cmd_valid_i && (state_q == StIdle);

   always_comb begin
      state_d     = state_q;
      cmd_ready_o = 1'b0;
      mem_re_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = 8'h00;
      done_o      = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) state_d = StRdA;
         end
         StRdA: begin
            mem_re_o   = 1'b1;
            mem_addr_o = src_a_q;
            state_d    = StRdB;
         end
         StRdB: begin
            mem_re_o   = 1'b1;
            mem_addr_o = src_b_q;
            state_d    = StLoad;
         end
         StLoad: state_d = StExec;
         StExec: state_d = StWb;
         StWb: begin
            mem_we_o    = 1'b1;
            mem_addr_o  = dst_q;
            mem_wdata_o = alu_result_i;
            done_o      = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         op_q          <= 2'b00;
         src_a_q       <= '0;
         src_b_q       <= '0;
         dst_q         <= '0;
         opa_q         <= 8'h00;
         alu_a_q       <= 8'h00;
         alu_b_q       <= 8'h00;
         alu_op_q      <= 2'b00;
         done_result_q <= 8'h00;
         op_count_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= cmd_op_i;
            src_a_q <= cmd_src_a_i;
            src_b_q <= cmd_src_b_i;
            dst_q   <= cmd_dst_i;
         end
         if (state_q == StRdB) opa_q <= mem_rdata_i;
         // Operand B lands straight in the ALU register so it is stable throughout EXEC.
         if (state_q == StLoad) begin
            alu_a_q  <= opa_q;
            alu_b_q  <= mem_rdata_i;
            alu_op_q <= op_q;
         end
         if (state_q == StWb) begin
            done_result_q <= alu_result_i;
            op_count_q    <= op_count_q + 8'd1;
         end
      end
   end

   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign alu_opcode_o  = alu_op_q;
   assign done_result_o = done_result_q;
   assign op_count_o    = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: RAM and registered-ALU models, a vector table, corner-case
// sequences and a randomized back-to-back run checked against a shadow-RAM scoreboard.
module tb_alu_sequencer;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] src_a, src_b, dst;
   logic [AW-1:0] mem_addr;
   logic          mem_re, mem_we;
   logic [7:0]    mem_rdata, mem_wdata;
   logic [7:0]    alu_a, alu_b, alu_result;
   logic [1:0]    alu_op;
   logic          done;
   logic [7:0]    done_result, op_count;

   always #5 clk = ~clk;

   alu_sequencer #(.ADDR_W(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_src_a_i(src_a), .cmd_src_b_i(src_b), .cmd_dst_i(dst),
      .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata),
      .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_op), .alu_result_i(alu_result),
      .done_o(done), .done_result_o(done_result), .op_count_o(op_count)
   );

   logic [7:0] ram    [256];
   logic [7:0] shadow [256];
   logic       pre_we;
   logic [7:0] pre_addr, pre_data;
   int         n_tests = 0, n_fail = 0;
   int         both_bad = 0, we_cnt = 0;
   logic [7:0] exp_cnt;

   function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   // Environment: synchronous RAM (1-cycle read) and a registered ALU.
   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
      alu_result <= alu_ref(alu_op, alu_a, alu_b);
      if (mem_re && mem_we) both_bad <= both_bad + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] v);
      pre_we = 1'b1; pre_addr = a; pre_data = v; shadow[a] = v;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, " cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({nm, " mem_re"}, 32'(mem_re), 32'd0);
      check({nm, " mem_we"}, 32'(mem_we), 32'd0);
      check({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
      check({nm, " mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({nm, " alu_a"}, 32'(alu_a), 32'd0);
      check({nm, " alu_b"}, 32'(alu_b), 32'd0);
      check({nm, " alu_op"}, 32'(alu_op), 32'd0);
      check({nm, " done"}, 32'(done), 32'd0);
      check({nm, " done_result"}, 32'(done_result), 32'd0);
      check({nm, " op_count"}, 32'(op_count), 32'd0);
   endtask

   // Issue one command from an IDLE negedge; returns at the negedge of cycle 6.
   task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, input logic [7:0] ex, input string nm);
      int         wb_cyc;
      logic       rdy_bad, g_done;
      logic [7:0] g_addr, g_data;
      check({nm, " ready"}, 32'(cmd_ready), 32'd1);
      cmd_op = op; src_a = a; src_b = b; dst = d; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      wb_cyc = 0; rdy_bad = 1'b0; g_done = 1'b0; g_addr = '0; g_data = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (cmd_ready) rdy_bad = 1'b1;
         if (mem_we && wb_cyc == 0) begin
            wb_cyc = c; g_addr = mem_addr; g_data = mem_wdata; g_done = done;
         end
      end
      @(negedge clk);
      shadow[d] = ex;
      exp_cnt   = exp_cnt + 8'd1;
      check({nm, " wb cycle"}, 32'(wb_cyc), 32'd5);
      check({nm, " wb addr"}, 32'(g_addr), 32'(d));
      check({nm, " wb data"}, 32'(g_data), 32'(ex));
      check({nm, " done"}, 32'(g_done), 32'd1);
      check({nm, " busy ready"}, 32'(rdy_bad), 32'd0);
      check({nm, " op_count"}, 32'(op_count), 32'(exp_cnt));
      check({nm, " done_result"}, 32'(done_result), 32'(ex));
      check({nm, " ram"}, 32'(ram[d]), 32'(ex));
      check({nm, " ready again"}, 32'(cmd_ready), 32'd1);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] a, b, d, va, vb, ex;
   } vec_t;

   typedef struct {
      logic [7:0] addr, data;
   } wb_t;

   initial begin
      vec_t       vt [6];
      wb_t        q [$];
      wb_t        e;
      logic [1:0] op;
      logic [7:0] a, b, d, ex, v0, start_cnt;
      int         we0, dones, accepts, gap_bad, last, cyc;

      vt[0] = '{op: 2'd0, a: 8'h10, b: 8'h11, d: 8'h20, va: 8'h05, vb: 8'h03, ex: 8'h08};
      vt[1] = '{op: 2'd1, a: 8'h10, b: 8'h11, d: 8'h21, va: 8'h03, vb: 8'h05, ex: 8'hFE};
      vt[2] = '{op: 2'd0, a: 8'h12, b: 8'h13, d: 8'h22, va: 8'hFF, vb: 8'h01, ex: 8'h00};
      vt[3] = '{op: 2'd2, a: 8'h14, b: 8'h15, d: 8'h23, va: 8'hF0, vb: 8'h3C, ex: 8'h30};
      vt[4] = '{op: 2'd3, a: 8'h14, b: 8'h15, d: 8'h24, va: 8'hF0, vb: 8'h3C, ex: 8'hFC};
      vt[5] = '{op: 2'd0, a: 8'h40, b: 8'h40, d: 8'h40, va: 8'h07, vb: 8'h07, ex: 8'h0E};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; src_a = '0; src_b = '0; dst = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0; exp_cnt = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         preload(vt[i].a, vt[i].va);
         preload(vt[i].b, vt[i].vb);
         do_cmd(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].ex, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 20; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         d  = 8'($urandom_range(0, 255));
         do_cmd(op, a, b, d, alu_ref(op, shadow[a], shadow[b]), $sformatf("rand%0d", i));
      end

      // Reset during EXEC must abort without a write.
      preload(8'h50, 8'h33);
      preload(8'h51, 8'h44);
      v0 = shadow[8'h60];
      cmd_op = 2'd3; src_a = 8'h50; src_b = 8'h51; dst = 8'h60; cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      we0 = we_cnt;
      repeat (4) @(negedge clk);
      check("exec alu_a", 32'(alu_a), 32'h33);
      check("exec alu_b", 32'(alu_b), 32'h44);
      check("exec alu_op", 32'(alu_op), 32'd3);
      rst_n = 1'b0;
      #1 check_reset_outputs("mid reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort no write", 32'(we_cnt - we0), 32'd0);
      check("abort ram kept", 32'(ram[8'h60]), 32'(v0));
      exp_cnt = 8'h00;
      do_cmd(2'd3, 8'h50, 8'h51, 8'h60, 8'h77, "post reset");

      // 256 back-to-back commands with cmd_valid held high.
      start_cnt = op_count; dones = 0; accepts = 0; gap_bad = 0; last = -1; cyc = 0;
      cmd_op = 2'($urandom_range(0, 3)); src_a = 8'($urandom_range(0, 255));
      src_b = 8'($urandom_range(0, 255)); dst = 8'($urandom_range(0, 255));
      cmd_valid = 1'b1;
      while ((accepts < 256 || q.size() > 0) && cyc < 2000) begin
         if (done) dones++;
         if (mem_we) begin
            check("b2b queue nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("b2b wb addr", 32'(mem_addr), 32'(e.addr));
               check("b2b wb data", 32'(mem_wdata), 32'(e.data));
            end
         end
         if (cmd_ready && cmd_valid) begin
            e.addr = dst;
            e.data = alu_ref(cmd_op, shadow[src_a], shadow[src_b]);
            q.push_back(e);
            shadow[dst] = e.data;
            if (last >= 0 && cyc - last != 6) gap_bad++;
            last = cyc;
            accepts++;
            @(posedge clk);
            #1;
            if (accepts == 256) cmd_valid = 1'b0;
            else begin
               cmd_op = 2'($urandom_range(0, 3)); src_a = 8'($urandom_range(0, 255));
               src_b = 8'($urandom_range(0, 255)); dst = 8'($urandom_range(0, 255));
            end
         end
         @(negedge clk);
         cyc++;
      end
      check("b2b no timeout", 32'(cyc < 2000), 32'd1);
      check("b2b accepts", 32'(accepts), 32'd256);
      check("b2b done pulses", 32'(dones), 32'd256);
      check("b2b accept spacing", 32'(gap_bad), 32'd0);
      check("b2b op_count wrap", 32'(op_count), 32'(start_cnt));
      check("re/we exclusive", 32'(both_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
